// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver.
// Segment codes are active-high {g,f,e,d,c,b,a}; output polarity is applied at the pin registers.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef logic [1:0] digit_idx_t;

  // Active-high one-hot digit enable for a scan position.
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input digit_idx_t idx);
    logic [NUM_DIGITS-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/seg7_bcd_scan_driver_if.sv
// Display-side bundle: BCD count and enable in, segment/anode pins and frame pulse out.
interface seg7_bcd_scan_driver_if;
  import seg7_pkg::*;

  logic [15:0]           bcdint;
  logic                  disp_en;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  frame_tick;

  modport master (
    output bcdint,
    output disp_en,
    input  seg,
    input  an,
    input  frame_tick
  );

  modport slave (
    input  bcdint,
    input  disp_en,
    output seg,
    output an,
    output frame_tick
  );
endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-high 7-segment code; invalid BCD (10-15) shows a dash.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_bcd_scan_driver.sv
// Resynchronises a packed-BCD count, freezes it per scan frame and multiplexes four digits.
// Define SEG7_LZ_BLANK_EN to blank leading zeros on the upper three digits.
module seg7_bcd_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned DIGIT_HZ    = 1_000,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          AN_ACT_LOW  = 1'b1
) (
  input logic                    clk50,
  input logic                    sys_init_ctrl_n,
  seg7_bcd_scan_driver_if.slave  disp_io
);

  localparam int unsigned PRESCALE = CLK_HZ / DIGIT_HZ;
  localparam int unsigned CntW     = $clog2(PRESCALE);
  localparam logic [CntW-1:0]       CntMax = CntW'(PRESCALE - 1);
  localparam logic [6:0]            SegOff = SEG_ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AnOff  = AN_ACT_LOW ? '1 : '0;

  logic [15:0]           sync1_q, sync2_q, stable_q, disp_val_q;
  logic [15:0]           stable_d, disp_val_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  digit_idx_t            digit_idx_q, digit_idx_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;

  logic                  scan_tick;
  logic                  frame_load;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [6:0]            seg_hi;
  logic [NUM_DIGITS-1:0] an_hi;
  logic                  blank;

  seg7_decode u_decode (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_comb begin
    scan_tick  = (cnt_q == CntMax);
    frame_load = scan_tick && (digit_idx_q == digit_idx_t'(NUM_DIGITS - 1));

    cnt_d        = scan_tick ? '0 : cnt_q + 1'b1;
    digit_idx_d  = scan_tick ? digit_idx_q + 2'd1 : digit_idx_q;
    frame_tick_d = frame_load;

    // Only accept a new count once two consecutive samples agree.
    stable_d   = (sync1_q == sync2_q) ? sync2_q : stable_q;
    disp_val_d = frame_load ? stable_q : disp_val_q;

    nibble = 4'(disp_val_q >> {digit_idx_q, 2'b00});
`ifdef SEG7_LZ_BLANK_EN
    // A digit is a leading zero when it and every digit above it are zero.
    blank = (digit_idx_q != '0) && ((disp_val_q >> {digit_idx_q, 2'b00}) == 16'h0000);
`else
    blank = 1'b0;
`endif
    seg_hi = blank ? SEG_OFF : dec_seg;
    an_hi  = digit_onehot(digit_idx_q);

    if (disp_io.disp_en) begin
      an_d  = AN_ACT_LOW ? ~an_hi : an_hi;
      seg_d = SEG_ACT_LOW ? ~seg_hi : seg_hi;
    end else begin
      an_d  = AnOff;
      seg_d = SegOff;
    end
  end

  always_ff @(posedge clk50 or negedge sys_init_ctrl_n) begin
    if (!sys_init_ctrl_n) begin
      sync1_q      <= 16'h0000;
      sync2_q      <= 16'h0000;
      stable_q     <= 16'h0000;
      disp_val_q   <= 16'h0000;
      cnt_q        <= '0;
      digit_idx_q  <= '0;
      frame_tick_q <= 1'b0;
      an_q         <= AnOff;
      seg_q        <= SegOff;
    end else begin
      sync1_q      <= disp_io.bcdint;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      disp_val_q   <= disp_val_d;
      cnt_q        <= cnt_d;
      digit_idx_q  <= digit_idx_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign disp_io.seg        = seg_q;
  assign disp_io.an         = an_q;
  assign disp_io.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_bcd_scan_driver.sv
// Self-checking bench for seg7_bcd_scan_driver (PRESCALE=4, active-low pins).
module tb_seg7_bcd_scan_driver;

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  localparam int HMAX = 8192;

  logic clk50 = 1'b0;
  logic rst_n;
  always #5 clk50 = ~clk50;

  seg7_bcd_scan_driver_if dif ();

  seg7_bcd_scan_driver #(
    .CLK_HZ      (400),
    .DIGIT_HZ    (100),
    .SEG_ACT_LOW (1'b1),
    .AN_ACT_LOW  (1'b1)
  ) dut (
    .clk50           (clk50),
    .sys_init_ctrl_n (rst_n),
    .disp_io         (dif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] hist [HMAX];
  bit          en_h [HMAX];
  logic [15:0] fv   [HMAX/16];
  int          k = 0;
  bit          model_on = 1'b0;

  function automatic logic [6:0] letters(input string s);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b1;
    return r;
  endfunction

  function automatic string digit_letters(input logic [3:0] n);
    case (n)
      4'd0: return "abcdef";
      4'd1: return "bc";
      4'd2: return "abdeg";
      4'd3: return "abcdg";
      4'd4: return "bcfg";
      4'd5: return "acdfg";
      4'd6: return "acdefg";
      4'd7: return "abc";
      4'd8: return "abcdefg";
      4'd9: return "abcdfg";
      default: return "g";
    endcase
  endfunction

  // Value loaded at wrap edge w: latest pair of equal consecutive samples old enough to be stable.
  function automatic logic [15:0] stable_for_load(input int w);
    for (int j = w - 3; j >= 0; j--) if (hist[j] == hist[j+1]) return hist[j];
    return 16'h0000;
  endfunction

  initial begin
    forever begin
      @(posedge clk50 or negedge rst_n);
      if (!rst_n) begin
        k       = 0;
        hist[0] = 16'h0000;
        fv[0]   = 16'h0000;
      end else if (k < HMAX - 1) begin
        k++;
        hist[k] = dif.bcdint;
        en_h[k] = dif.disp_en;
        if (k % 16 == 0) fv[k/16] = stable_for_load(k);
      end
    end
  end

  initial begin
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic        ft_e;
    logic [15:0] val;
    logic [3:0]  nib;
    int          d;
    forever begin
      @(negedge clk50);
      if (model_on) begin
        if (!rst_n || k == 0) begin
          an_e = 4'hF; seg_e = 7'h7F; ft_e = 1'b0;
        end else begin
          d     = ((k - 1) / 4) % 4;
          val   = fv[(k - 1) / 16];
          ft_e  = (k % 16 == 0);
          an_e  = 4'hF;
          seg_e = 7'h7F;
          if (en_h[k]) begin
            an_e[d] = 1'b0;
            nib     = val[d*4 +: 4];
            if (!(LZ && d > 0 && (val >> (4 * d)) == 16'h0000))
              seg_e = ~letters(digit_letters(nib));
          end
        end
        check("model_an", {12'h0, dif.an}, {12'h0, an_e});
        check("model_seg", {9'h0, dif.seg}, {9'h0, seg_e});
        check("model_tick", {15'h0, dif.frame_tick}, {15'h0, ft_e});
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_tick(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk50);
      seen = dif.frame_tick;
    end
    check(name, {15'h0, seen}, 16'h0001);
  endtask

  // Call right after the negedge that saw frame_tick.
  task automatic check_frame(input string name, input logic [3:0][6:0] exp);
    logic [3:0] an_e;
    int d;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk50);
      if (i % 4 == 1) begin
        d       = (i - 1) / 4;
        an_e    = 4'hF;
        an_e[d] = 1'b0;
        check({name, "_seg"}, {9'h0, dif.seg}, {9'h0, exp[d]});
        check({name, "_an"}, {12'h0, dif.an}, {12'h0, an_e});
      end
    end
  endtask

  typedef struct packed {
    logic [15:0]      bcd;
    logic [3:0][6:0]  seg;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int       hold;
    int       ticks;
    logic [6:0] z;
    z = LZ ? 7'h7F : 7'h40;

    vecs[0] = '{bcd: 16'h1234, seg: {7'h79, 7'h24, 7'h30, 7'h19}};
    vecs[1] = '{bcd: 16'h5678, seg: {7'h12, 7'h02, 7'h78, 7'h00}};
    vecs[2] = '{bcd: 16'h9090, seg: {7'h10, 7'h40, 7'h10, 7'h40}};
    vecs[3] = '{bcd: 16'hA0F3, seg: {7'h3F, 7'h40, 7'h3F, 7'h30}};
    vecs[4] = '{bcd: 16'h0050, seg: {z, z, 7'h12, 7'h40}};
    vecs[5] = '{bcd: 16'h0000, seg: {z, z, z, 7'h40}};
    vecs[6] = '{bcd: 16'h0B00, seg: {z, 7'h3F, 7'h40, 7'h40}};
    vecs[7] = '{bcd: 16'hF00F, seg: {7'h3F, 7'h40, 7'h40, 7'h3F}};

    hist[0]     = 16'h0000;
    fv[0]       = 16'h0000;
    rst_n       = 1'b0;
    dif.bcdint  = 16'h0000;
    dif.disp_en = 1'b1;
    model_on    = 1'b1;

    // Reset state
    repeat (3) @(negedge clk50);
    check("rst_an", {12'h0, dif.an}, 16'h000F);
    check("rst_seg", {9'h0, dif.seg}, 16'h007F);
    check("rst_tick", {15'h0, dif.frame_tick}, 16'h0000);
    rst_n = 1'b1;

    // First frame after release shows 0000, scanning units first
    check_frame("first_frame", {z, z, z, 7'h40});

    // Table of held values
    foreach (vecs[v]) begin
      dif.bcdint = vecs[v].bcd;
      wait_tick("vec_tick_a");
      wait_tick("vec_tick_b");
      check_frame($sformatf("vec%0d", v), vecs[v].seg);
    end

    // Mid-frame change does not tear the current frame
    dif.bcdint = 16'h1234;
    wait_tick("mid_tick_a");
    wait_tick("mid_tick_b");
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk50);
      if (i % 4 == 1) check("mid_seg", {9'h0, dif.seg}, {9'h0, vecs[0].seg[(i-1)/4]});
      if (i == 6) dif.bcdint = 16'h5678;
    end
    wait_tick("mid_tick_c");
    check_frame("mid_new", vecs[1].seg);

    // Glitch reject: toggling every clock never updates the display
    dif.bcdint = 16'h0009;
    wait_tick("gl_tick_a");
    wait_tick("gl_tick_b");
    for (int i = 0; i < 64; i++) begin
      @(negedge clk50);
      if (dif.an == 4'b1110) check("glitch_d0", {9'h0, dif.seg}, 16'h0010);
      if (dif.an == 4'b1101) check("glitch_d1", {9'h0, dif.seg}, {9'h0, z});
      dif.bcdint = (i % 2 == 0) ? 16'h0010 : 16'h0009;
    end
    dif.bcdint = 16'h0010;
    wait_tick("gl_tick_c");
    wait_tick("gl_tick_d");
    check_frame("glitch_hold", {z, z, 7'h79, 7'h40});

    // disp_en drop mid-digit, frame_tick keeps running
    wait_tick("en_tick");
    repeat (6) @(negedge clk50);
    dif.disp_en = 1'b0;
    @(negedge clk50);
    check("en_off_an", {12'h0, dif.an}, 16'h000F);
    check("en_off_seg", {9'h0, dif.seg}, 16'h007F);
    ticks = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk50);
      if (dif.frame_tick) ticks++;
    end
    check("en_off_ticks", 16'(ticks), 16'd2);
    dif.disp_en = 1'b1;
    @(negedge clk50);
    check("en_resume_an", {12'h0, dif.an}, 16'h000D);

    // Asynchronous reset mid-frame darkens outputs immediately
    repeat (5) @(negedge clk50);
    #2 rst_n = 1'b0;
    #1;
    check("arst_an", {12'h0, dif.an}, 16'h000F);
    check("arst_seg", {9'h0, dif.seg}, 16'h007F);
    check("arst_tick", {15'h0, dif.frame_tick}, 16'h0000);
    @(negedge clk50);
    rst_n = 1'b1;

    // Randomized run against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk50);
      if (hold == 0) begin
        case ($urandom_range(0, 9))
          0, 1:    dif.bcdint = 16'($urandom);
          2, 3:    dif.bcdint = {8'h00, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
          default: dif.bcdint = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        endcase
        hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(2, 40));
      end
      hold--;
      if ($urandom_range(0, 29) == 0) dif.disp_en = ~dif.disp_en;
    end

    @(negedge clk50);
    model_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
